// File: rtl/enc_dec_pkg.sv
// Shared definitions for the ECC engine APB driver: register map, job mode
// and result status encodings, and the state encodings of both FSMs.
package enc_dec_pkg;

    // Engine register offsets from the base address.
    localparam logic [7:0] REG_CTRL     = 8'h0;
    localparam logic [7:0] REG_DATA_IN  = 8'h4;
    localparam logic [7:0] REG_CW_WIDTH = 8'h8;
    localparam logic [7:0] REG_NOISE    = 8'hC;

    // Write index order; CTRL is last because writing it starts the engine.
    localparam logic [1:0] WI_DATA_IN  = 2'd0;
    localparam logic [1:0] WI_CW_WIDTH = 2'd1;
    localparam logic [1:0] WI_NOISE    = 2'd2;
    localparam logic [1:0] WI_CTRL     = 2'd3;

    typedef enum logic [1:0] {
        MODE_ENC     = 2'b00,
        MODE_DEC     = 2'b01,
        MODE_FULL    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_TIMEOUT = 2'b01,
        STATUS_ILLEGAL = 2'b10
    } res_status_t;

    // Main driver FSM; the SETUP/ACCESS phases live in the write sequencer.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESULT    = 2'd3
    } drv_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_SETUP  = 2'd1,
        SEQ_ACCESS = 2'd2
    } seq_phase_t;

    // Register offset addressed by a given write index.
    function automatic logic [7:0] reg_offset(input logic [1:0] wi);
        logic [7:0] off;
        case (wi)
            WI_DATA_IN:  off = REG_DATA_IN;
            WI_CW_WIDTH: off = REG_CW_WIDTH;
            WI_NOISE:    off = REG_NOISE;
            default:     off = REG_CTRL;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/enc_dec_apb_driver_if.sv
// Bundle of the driver's job, APB, engine-status and result signals.
// Handshake rule for both job_* and res_*: a transfer happens on a rising
// clk edge where valid and ready are both high; the offering side holds
// its payload stable while valid is high and ready is low.
// The master modport is the driver's view, slave is its environment's.
interface enc_dec_apb_driver_if
    import enc_dec_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic                       job_valid;
    logic                       job_ready;
    logic [1:0]                 job_mode;
    logic [1:0]                 job_width;
    logic [DATA_WIDTH-1:0]      job_data;
    logic [DATA_WIDTH-1:0]      job_noise;

    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;

    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;

    logic                       res_valid;
    logic                       res_ready;
    logic [DATA_WIDTH-1:0]      res_data;
    logic [1:0]                 res_errors;
    logic [1:0]                 res_status;

    logic                       busy;
    drv_state_t                 dbg_state;
    seq_phase_t                 dbg_phase;

    modport master (
        input  job_valid, job_mode, job_width, job_data, job_noise,
        input  operation_done, data_out, num_of_errors, res_ready,
        output job_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output res_valid, res_data, res_errors, res_status, busy,
        output dbg_state, dbg_phase
    );

    modport slave (
        output job_valid, job_mode, job_width, job_data, job_noise,
        output operation_done, data_out, num_of_errors, res_ready,
        input  job_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  res_valid, res_data, res_errors, res_status, busy,
        input  dbg_state, dbg_phase
    );

endinterface

// File: rtl/enc_dec_apb_driver_apb_write_seq.sv
// Single APB write engine: a start pulse launches a SETUP cycle followed by
// an ACCESS cycle. o_done is high during ACCESS; a start seen in that cycle
// chains straight into the next SETUP so transfers run back to back.
// All APB outputs are registered and return to zero when idle.
module apb_write_seq
    import enc_dec_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [AMBA_ADDR_WIDTH-1:0] i_addr,
    input  logic [AMBA_WORD-1:0]       i_wdata,
    output logic                       o_done,
    output seq_phase_t                 o_phase,
    output logic [AMBA_ADDR_WIDTH-1:0] o_paddr,
    output logic [AMBA_WORD-1:0]       o_pwdata,
    output logic                       o_psel,
    output logic                       o_penable,
    output logic                       o_pwrite
);
    seq_phase_t                 r_phase;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;

    // SETUP -> ACCESS sequencing with registered APB outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= SEQ_IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
        end else begin
            case (r_phase)
                SEQ_IDLE: begin
                    if (i_start) begin
                        r_phase   <= SEQ_SETUP;
                        r_paddr   <= i_addr;
                        r_pwdata  <= i_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b1;
                    end
                end
                SEQ_SETUP: begin
                    r_phase   <= SEQ_ACCESS;
                    r_penable <= 1'b1;
                end
                SEQ_ACCESS: begin
                    if (i_start) begin
                        r_phase   <= SEQ_SETUP;
                        r_paddr   <= i_addr;
                        r_pwdata  <= i_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b1;
                    end else begin
                        r_phase   <= SEQ_IDLE;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                    end
                end
                default: begin
                    r_phase   <= SEQ_IDLE;
                    r_paddr   <= '0;
                    r_pwdata  <= '0;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_pwrite  <= 1'b0;
                end
            endcase
        end
    end

    // The engine has no PREADY, so every ACCESS cycle completes its transfer.
    assign o_done    = (r_phase == SEQ_ACCESS);
    assign o_phase   = r_phase;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;

endmodule

// File: rtl/enc_dec_apb_driver.sv
// APB master feeding the ECC encode/decode engine. Accepts one job, writes
// DATA_IN, CODEWORD_WIDTH, NOISE and finally CTRL (which starts the engine),
// waits for operation_done with a timeout, and returns a result with status.
// Optional build macro ENC_DEC_WRITE_CACHE_EN: remember the last written
// width and noise and skip those writes when a new job repeats them.
module enc_dec_apb_driver
    import enc_dec_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int BASE_ADDR       = 0,
    parameter int TIMEOUT_CYCLES  = 64
)(
    input  logic                 clk,
    input  logic                 rst,
    enc_dec_apb_driver_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    drv_state_t                 r_state;
    logic [1:0]                 r_wi;
    logic [1:0]                 r_mode;
    logic [1:0]                 r_width;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [DATA_WIDTH-1:0]      r_noise;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_job_ready;
    logic                       r_busy;
    logic                       r_res_valid;
    logic [DATA_WIDTH-1:0]      r_res_data;
    logic [1:0]                 r_res_errors;
    logic [1:0]                 r_res_status;

    logic                       w_accept;
    logic                       w_seq_start;
    logic                       w_seq_done;
    logic                       w_skip_width;
    logic                       w_skip_noise;
    logic [1:0]                 w_next_wi;
    logic [1:0]                 w_start_wi;
    logic [AMBA_ADDR_WIDTH-1:0] w_wr_addr;
    logic [AMBA_WORD-1:0]       w_wr_data;

    assign w_accept = r_job_ready && bus.job_valid;

`ifdef ENC_DEC_WRITE_CACHE_EN
    logic                  r_cache_valid;
    logic [1:0]            r_cache_width;
    logic [DATA_WIDTH-1:0] r_cache_noise;

    // Record width/noise as their writes complete; the cache only becomes
    // valid once a full job has reached its CTRL write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_valid <= 1'b0;
            r_cache_width <= '0;
            r_cache_noise <= '0;
        end else if (r_state == ST_WRITE && w_seq_done) begin
            case (r_wi)
                WI_CW_WIDTH: r_cache_width <= r_width;
                WI_NOISE:    r_cache_noise <= r_noise;
                WI_CTRL:     r_cache_valid <= 1'b1;
                default:     ;
            endcase
        end
    end

    assign w_skip_width = r_cache_valid && (r_cache_width == r_width);
    assign w_skip_noise = r_cache_valid && (r_cache_noise == r_noise);
`else
    assign w_skip_width = 1'b0;
    assign w_skip_noise = 1'b0;
`endif

    // Next write index after the current one, stepping over skipped registers.
    always_comb begin
        w_next_wi = WI_CTRL;
        case (r_wi)
            WI_DATA_IN: begin
                if (!w_skip_width)      w_next_wi = WI_CW_WIDTH;
                else if (!w_skip_noise) w_next_wi = WI_NOISE;
            end
            WI_CW_WIDTH: begin
                if (!w_skip_noise)      w_next_wi = WI_NOISE;
            end
            default: ;
        endcase
    end

    // A new write starts on acceptance of a legal job or chained off a
    // finishing ACCESS while registers remain.
    assign w_start_wi  = (r_state == ST_IDLE) ? WI_DATA_IN : w_next_wi;
    assign w_seq_start = (w_accept && (bus.job_mode != MODE_ILLEGAL)) ||
                         ((r_state == ST_WRITE) && w_seq_done && (r_wi != WI_CTRL));
    assign w_wr_addr   = AMBA_ADDR_WIDTH'(BASE_ADDR) +
                         AMBA_ADDR_WIDTH'(reg_offset(w_start_wi));

    // Write payload for the register being started. DATA_IN is always the
    // first write and launches in the acceptance cycle, so it is taken
    // straight from the job inputs rather than from the latched copy.
    always_comb begin
        w_wr_data = '0;
        case (w_start_wi)
            WI_DATA_IN:  w_wr_data = AMBA_WORD'(bus.job_data);
            WI_CW_WIDTH: w_wr_data = AMBA_WORD'(r_width);
            WI_NOISE:    w_wr_data = AMBA_WORD'(r_noise);
            default:     w_wr_data = AMBA_WORD'(r_mode);
        endcase
    end

    apb_write_seq #(
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
        .AMBA_WORD       (AMBA_WORD)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_seq_start),
        .i_addr    (w_wr_addr),
        .i_wdata   (w_wr_data),
        .o_done    (w_seq_done),
        .o_phase   (bus.dbg_phase),
        .o_paddr   (bus.PADDR),
        .o_pwdata  (bus.PWDATA),
        .o_psel    (bus.PSEL),
        .o_penable (bus.PENABLE),
        .o_pwrite  (bus.PWRITE)
    );

    // Main job FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wi         <= WI_DATA_IN;
            r_mode       <= '0;
            r_width      <= '0;
            r_data       <= '0;
            r_noise      <= '0;
            r_cnt        <= '0;
            r_job_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_errors <= '0;
            r_res_status <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mode      <= bus.job_mode;
                        r_width     <= bus.job_width;
                        r_data      <= bus.job_data;
                        r_noise     <= bus.job_noise;
                        r_wi        <= WI_DATA_IN;
                        r_job_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.job_mode == MODE_ILLEGAL) begin
                            r_state      <= ST_RESULT;
                            r_res_valid  <= 1'b1;
                            r_res_data   <= '0;
                            r_res_errors <= '0;
                            r_res_status <= STATUS_ILLEGAL;
                        end else begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_seq_done) begin
                        if (r_wi == WI_CTRL) begin
                            r_state <= ST_WAIT_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_wi <= w_next_wi;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    // Completion takes priority over a simultaneous timeout.
                    if (bus.operation_done) begin
                        r_state      <= ST_RESULT;
                        r_res_valid  <= 1'b1;
                        r_res_data   <= bus.data_out;
                        r_res_errors <= bus.num_of_errors;
                        r_res_status <= STATUS_OK;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state      <= ST_RESULT;
                        r_res_valid  <= 1'b1;
                        r_res_data   <= '0;
                        r_res_errors <= '0;
                        r_res_status <= STATUS_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.job_ready  = r_job_ready;
    assign bus.busy       = r_busy;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_errors = r_res_errors;
    assign bus.res_status = r_res_status;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_enc_dec_apb_driver.sv
// Bench for enc_dec_apb_driver: directed vector table, reset-in-flight
// sequence, randomized jobs against a job-level reference model.
module tb_enc_dec_apb_driver;
    import enc_dec_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 20;
    localparam int WW   = 32;
    localparam int T    = 64;
    localparam int BASE = 0;
    localparam int W    = AW + WW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    enc_dec_apb_driver_if #(.DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW)) bus ();

    enc_dec_apb_driver #(
        .DATA_WIDTH      (DW),
        .AMBA_ADDR_WIDTH (AW),
        .AMBA_WORD       (WW),
        .BASE_ADDR       (BASE),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB observer: protocol shape and the list of completed writes.
    logic          mon_en = 1'b0;
    logic          prev_setup = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [WW-1:0] prev_data = '0;
    logic [W-1:0]  obs_q[$];
    int            psel_cycles = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.PSEL && !bus.PENABLE) begin
                check("setup_pwrite", bus.PWRITE, 1);
                prev_setup = 1'b1;
                prev_addr  = bus.PADDR;
                prev_data  = bus.PWDATA;
                psel_cycles++;
            end else if (bus.PSEL && bus.PENABLE) begin
                check("access_after_setup", {prev_setup, prev_addr, prev_data},
                      {1'b1, bus.PADDR, bus.PWDATA});
                check("access_pwrite", bus.PWRITE, 1);
                obs_q.push_back({bus.PADDR, bus.PWDATA});
                prev_setup = 1'b0;
                psel_cycles++;
            end else begin
                check("apb_idle_zero", {bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 64'd0);
                prev_setup = 1'b0;
            end
        end
    end

    // Reference model: expected write list and result for one job.
    logic         m_cache_valid = 1'b0;
    logic [1:0]   m_cache_w = '0;
    logic [DW-1:0] m_cache_n = '0;
    logic [W-1:0] exp_q[$];

    function automatic void build_exp(input logic [1:0] mode, input logic [1:0] width,
                                      input logic [DW-1:0] data, input logic [DW-1:0] noise);
        exp_q.delete();
        if (mode == 2'b11) return;
        exp_q.push_back({AW'(BASE + 4), WW'(data)});
`ifdef ENC_DEC_WRITE_CACHE_EN
        if (!(m_cache_valid && m_cache_w == width)) exp_q.push_back({AW'(BASE + 8), WW'(width)});
        if (!(m_cache_valid && m_cache_n == noise)) exp_q.push_back({AW'(BASE + 12), WW'(noise)});
`else
        exp_q.push_back({AW'(BASE + 8), WW'(width)});
        exp_q.push_back({AW'(BASE + 12), WW'(noise)});
`endif
        exp_q.push_back({AW'(BASE), WW'(mode)});
    endfunction

    function automatic void model_result(input logic [1:0] mode, input int delay,
                                         input logic [DW-1:0] dout, input logic [1:0] nerr,
                                         output logic [1:0] st, output logic [DW-1:0] d,
                                         output logic [1:0] e);
        if (mode == 2'b11) begin
            st = 2'b10; d = '0; e = '0;
        end else if (delay >= 0 && delay <= T - 1) begin
            st = 2'b00; d = dout; e = nerr;
        end else begin
            st = 2'b01; d = '0; e = '0;
        end
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_cache_valid = 1'b0;
        m_cache_w = '0;
        m_cache_n = '0;
    endtask

    // Drive one job end to end and compare everything observable about it.
    task automatic run_job(input logic [1:0] mode, input logic [1:0] width,
                           input logic [DW-1:0] data, input logic [DW-1:0] noise,
                           input int delay, input logic [DW-1:0] dout, input logic [1:0] nerr,
                           input int hold, input logic [1:0] exp_st,
                           input logic [DW-1:0] exp_data, input logic [1:0] exp_err,
                           input string tag);
        int acc_cyc, ctrl_cyc, res_cyc, nexp;
        bit ok, ok_ctrl, ok_res;
        build_exp(mode, width, data, noise);
        nexp = exp_q.size();
        obs_q.delete();
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_mode  = mode;
        bus.job_width = width;
        bus.job_data  = data;
        bus.job_noise = noise;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.job_ready) begin ok = 1'b1; acc_cyc = cyc; end
        end
        check({tag, " accept"}, ok, 1);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        bus.job_mode  = 2'($urandom);
        bus.job_width = 2'($urandom);
        bus.job_data  = $urandom;
        bus.job_noise = $urandom;
        if (!ok) return;
        ok_ctrl = 1'b0;
        ok_res  = 1'b0;
        fork
            begin
                if (mode != 2'b11) begin
                    for (int i = 0; i < 40 && !ok_ctrl; i++) begin
                        @(negedge clk);
                        if (bus.PSEL && bus.PENABLE && bus.PADDR == AW'(BASE)) begin
                            ok_ctrl = 1'b1; ctrl_cyc = cyc;
                        end
                    end
                    check({tag, " ctrl_write_seen"}, ok_ctrl, 1);
                    if (ok_ctrl) begin
                        check({tag, " busy_no_ready"}, {bus.busy, bus.job_ready}, 2'b10);
                        check({tag, " ctrl_latency"}, ctrl_cyc - acc_cyc, 2 * nexp);
                        if (delay >= 0) begin
                            repeat (delay + 1) @(posedge clk);
                            #1;
                            bus.operation_done = 1'b1;
                            bus.data_out       = dout;
                            bus.num_of_errors  = nerr;
                            @(posedge clk);
                            #1;
                            bus.operation_done = 1'b0;
                            bus.data_out       = $urandom;
                            bus.num_of_errors  = 2'($urandom);
                        end
                    end
                end
            end
            begin
                for (int i = 0; i < T + 60 && !ok_res; i++) begin
                    @(negedge clk);
                    if (bus.res_valid) begin ok_res = 1'b1; res_cyc = cyc; end
                end
            end
        join
        check({tag, " res_valid_seen"}, ok_res, 1);
        if (!ok_res) return;
        if (mode == 2'b11)
            check({tag, " illegal_latency"}, res_cyc - acc_cyc, 1);
        else if (ok_ctrl && exp_st == 2'b00)
            check({tag, " done_latency"}, res_cyc - ctrl_cyc, delay + 2);
        else if (ok_ctrl)
            check({tag, " timeout_latency"}, res_cyc - ctrl_cyc, T + 1);
        check({tag, " result"}, {bus.res_status, bus.res_errors, bus.res_data},
              {exp_st, exp_err, exp_data});
        check({tag, " result_busy"}, {bus.busy, bus.job_ready}, 2'b10);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " result_held"}, {bus.res_valid, bus.res_status, bus.res_errors, bus.res_data},
                  {1'b1, exp_st, exp_err, exp_data});
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check({tag, " after_handshake"}, {bus.res_valid, bus.job_ready, bus.busy}, 3'b010);
        check({tag, " n_writes"}, obs_q.size(), nexp);
        for (int i = 0; i < nexp && i < obs_q.size(); i++)
            check({tag, " write"}, obs_q[i], exp_q[i]);
        if (mode != 2'b11) begin
            m_cache_valid = 1'b1;
            m_cache_w = width;
            m_cache_n = noise;
        end
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [1:0]    width;
        logic [DW-1:0] data;
        logic [DW-1:0] noise;
        int            delay;
        logic [DW-1:0] dout;
        logic [1:0]    nerr;
        int            hold;
        logic [1:0]    st;
        logic [DW-1:0] rdata;
        logic [1:0]    rerr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    r_mode, r_width, r_nerr, e_st, e_err;
        logic [DW-1:0] r_data, r_noise, r_dout, e_data;
        int            r_delay, sel, seen;
        bit            ok;

        vecs[0] = '{2'b00, 2'b00, 32'h5,        32'h0,        0,  32'h5A,       2'b00, 0, 2'b00, 32'h5A,       2'b00};
        vecs[1] = '{2'b10, 2'b01, 32'h12345678, 32'h1,        3,  32'hCAFEF00D, 2'b01, 2, 2'b00, 32'hCAFEF00D, 2'b01};
        vecs[2] = '{2'b01, 2'b10, 32'hFFFFFFFF, 32'h80000001, 10, 32'h1,        2'b10, 1, 2'b00, 32'h1,        2'b10};
        vecs[3] = '{2'b00, 2'b11, 32'hA,        32'h0,        -1, 32'h77,       2'b11, 0, 2'b01, 32'h0,        2'b00};
        vecs[4] = '{2'b01, 2'b11, 32'h3C,       32'h4,        T-1, 32'hBEEF,    2'b11, 0, 2'b00, 32'hBEEF,     2'b11};
        vecs[5] = '{2'b10, 2'b00, 32'h77,       32'h4,        T,  32'h1234,     2'b01, 0, 2'b01, 32'h0,        2'b00};
        vecs[6] = '{2'b11, 2'b01, 32'h99,       32'h2,        -1, 32'h0,        2'b00, 5, 2'b10, 32'h0,        2'b00};

        bus.job_valid = 1'b0;
        bus.job_mode = '0;
        bus.job_width = '0;
        bus.job_data = '0;
        bus.job_noise = '0;
        bus.operation_done = 1'b0;
        bus.data_out = '0;
        bus.num_of_errors = '0;
        bus.res_ready = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst job_ready", bus.job_ready, 1);
        check("rst apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 64'd0);
        check("rst result", {bus.res_valid, bus.res_status, bus.res_errors, bus.res_data}, 64'd0);
        check("rst busy", bus.busy, 0);
        check("rst state", bus.dbg_state, ST_IDLE);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset during the ACCESS of the NOISE write discards the job.
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_mode  = 2'b01;
        bus.job_width = 2'b01;
        bus.job_data  = 32'h0BAD;
        bus.job_noise = 32'h3;
        @(posedge clk);
        #1 bus.job_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.PSEL && bus.PENABLE && bus.PADDR == AW'(BASE + 12)) ok = 1'b1;
        end
        check("rstmid noise_access_seen", ok, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_cache_valid = 1'b0;
        @(negedge clk);
        check("rstmid apb_dropped", {bus.PSEL, bus.PENABLE}, 2'b00);
        check("rstmid job_ready", {bus.job_ready, bus.busy, bus.res_valid}, 3'b100);
        @(posedge clk);
        #1 bus.operation_done = 1'b1;
        @(posedge clk);
        #1 bus.operation_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid || bus.PSEL) seen++;
        end
        check("rstmid no_result_no_apb", seen, 0);
        obs_q.delete();

        // Directed vector table.
        for (int v = 0; v < 7; v++)
            run_job(vecs[v].mode, vecs[v].width, vecs[v].data, vecs[v].noise, vecs[v].delay,
                    vecs[v].dout, vecs[v].nerr, vecs[v].hold, vecs[v].st, vecs[v].rdata,
                    vecs[v].rerr, $sformatf("vec%0d", v));

`ifdef ENC_DEC_WRITE_CACHE_EN
        // Repeated width and noise: only DATA_IN and CTRL are written.
        apply_reset();
        run_job(2'b00, 2'b10, 32'h11, 32'h5, 2, 32'h21, 2'b00, 0, 2'b00, 32'h21, 2'b00, "cache_first");
        psel_cycles = 0;
        run_job(2'b01, 2'b10, 32'h22, 32'h5, 2, 32'h42, 2'b01, 0, 2'b00, 32'h42, 2'b01, "cache_second");
        check("cache second writes", obs_q.size(), 2);
        check("cache second apb_cycles", psel_cycles, 4);
`endif

        // Randomized jobs against the reference model.
        for (int n = 0; n < 25; n++) begin
            r_mode  = 2'($urandom_range(0, 3));
            r_width = 2'($urandom_range(0, 1));
            r_data  = $urandom;
            r_noise = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
            sel     = $urandom_range(0, 9);
            if (sel < 7)       r_delay = $urandom_range(0, 12);
            else if (sel == 7) r_delay = T - 1;
            else if (sel == 8) r_delay = T;
            else               r_delay = -1;
            r_dout  = $urandom;
            r_nerr  = 2'($urandom_range(0, 3));
            model_result(r_mode, r_delay, r_dout, r_nerr, e_st, e_data, e_err);
            run_job(r_mode, r_width, r_data, r_noise, r_delay, r_dout, r_nerr,
                    $urandom_range(0, 3), e_st, e_data, e_err, $sformatf("rand%0d", n));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_dec_apb_driver.md
Name: enc_dec_apb_driver

Overview:
- Upstream APB master that feeds the ECC encode/decode/full-channel engine.
- Accepts one job at a time on a valid/ready interface and programs the engine's four registers over APB, writing CTRL last.
- Waits for operation_done, then captures data_out and num_of_errors.
- Presents the captured values as a result on a valid/ready interface with a status code.

Parameters:
- DATA_WIDTH, 32: engine codeword width; the job data/noise width and the result data width.
- AMBA_ADDR_WIDTH, 20: PADDR width.
- AMBA_WORD, 32: PWDATA width.
- BASE_ADDR, 0: engine base address. Register offsets: CTRL +0x0, DATA_IN +0x4, CODEWORD_WIDTH +0x8, NOISE +0xC.
- TIMEOUT_CYCLES, 64: maximum cycles to wait for operation_done after the CTRL write.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when high together with job_valid
- job_mode  in  2  00 encode, 01 decode, 10 full channel, 11 illegal
- job_width  in  2  CODEWORD_WIDTH value
- job_data  in  DATA_WIDTH  DATA_IN value
- job_noise  in  DATA_WIDTH  NOISE value
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data, zero-extended
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB write
- operation_done  in  1  engine completion pulse
- data_out  in  DATA_WIDTH  engine result
- num_of_errors  in  2  engine error count
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high together with res_valid
- res_data  out  DATA_WIDTH  captured data_out
- res_errors  out  2  captured num_of_errors
- res_status  out  2  00 ok, 01 timeout, 10 illegal mode
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst sampled high at a clk edge): state IDLE. All outputs 0 except job_ready=1.
- Reset mid-operation: PSEL and PENABLE drop on the same edge. The job is discarded and no result is issued.
- States:
  - IDLE: job_ready=1. On job_valid, latch mode, width, data and noise and set write index wi=0.
    - If mode=11: go to RESULT with status 10, res_data=0, res_errors=0. No APB traffic.
    - Otherwise: go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA per wi. Next state ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, same address and data. The transfer completes in this single cycle (the engine has no PREADY).
    - If wi<3: wi++ and return to SETUP.
    - If wi=3: go to WAIT_DONE with the timeout counter cleared.
  - Write order by wi: 0 DATA_IN, 1 CODEWORD_WIDTH, 2 NOISE, 3 CTRL. CTRL last, because the CTRL write starts the engine.
  - Between transfers: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - WAIT_DONE: counter increments every cycle.
    - If operation_done=1: capture data_out and num_of_errors, status 00, go to RESULT.
    - Else, when the counter reaches TIMEOUT_CYCLES-1: status 01, res_data=0, res_errors=0, go to RESULT.
    - If operation_done arrives in the same cycle as the terminal count, done wins (status 00).
  - RESULT: res_valid=1 and result fields held stable until res_ready. On the handshake, go to IDLE; job_ready=1 from the next cycle.
- No job overlap: job_ready=0 from the acceptance cycle through the result handshake.
- operation_done outside WAIT_DONE is ignored.
- Latency, accept to first possible done: 8 cycles of APB traffic (4 transfers × 2 cycles) before the engine starts.

Optional Feature:
- ENC_DEC_WRITE_CACHE_EN
- Defined:
  - The block keeps the last width and noise successfully written, plus a cache-valid bit cleared by rst.
  - A job whose width or noise matches a valid cached value skips that APB write. wi advances directly past the skipped register.
  - The DATA_IN and CTRL writes are never skipped.
  - Illegal-mode jobs do not update the cache.
- Undefined: all four writes are issued for every job.

Decomposition:
- Shared package enc_dec_pkg:
  - register offset constants (CTRL/DATA_IN/CODEWORD_WIDTH/NOISE);
  - mode encodings (ENC=00, DEC=01, FULL=10);
  - res_status encodings;
  - driver state enum.
- Sub-module apb_write_seq: two-cycle SETUP/ACCESS single-write engine with a start/done pulse interface. The main FSM sequences it over wi.

Test Plan:
- Encode job, mode=00, width=00, data=0x5, noise=0; engine pulses done with data_out=0x5A, errors=0 → APB writes 0x4=0x5, 0x8=0x0, 0xC=0x0, 0x0=0x0 in order, each SETUP then ACCESS; result data=0x5A, errors=00, status=00.
- Full-channel job, mode=10, noise=0x1; engine returns errors=01 → CTRL write carries 0x2 and is last; res_errors=01, status=00.
- No operation_done after the CTRL write → res_valid rises exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE, status=01, res_data=0.
- Illegal mode=11 → no PSEL activity; res_valid next cycle, status=10; result held while res_ready=0 for 5 cycles, then released.
- rst asserted during the ACCESS of the NOISE write → PSEL=0, PENABLE=0 and job_ready=1 after that edge; no res_valid afterwards.
- With ENC_DEC_WRITE_CACHE_EN, two consecutive jobs with equal width and noise → the second job issues only the 0x4 and 0x0 writes (4 APB cycles).
